// File: rtl/brlshift_pipe_if.sv
// Operand/result handshake bundle for brlshift_pipe.
// The master drives operations and accepts results; the slave is the shifter.
interface brlshift_pipe_if #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 6
);
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       brlmux;
    logic [WIDTH-1:0] srcdp;
    logic [WIDTH-1:0] brld;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] brlq;
    logic             brl_carry;
    logic             brl_zero;
    logic             brl_neg;
    logic [TAG_W-1:0] out_tag;

    modport master (
        output in_valid,
        output brlmux,
        output srcdp,
        output brld,
        output in_tag,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  brlq,
        input  brl_carry,
        input  brl_zero,
        input  brl_neg,
        input  out_tag
    );

    modport slave (
        input  in_valid,
        input  brlmux,
        input  srcdp,
        input  brld,
        input  in_tag,
        input  out_ready,
        output in_ready,
        output out_valid,
        output brlq,
        output brl_carry,
        output brl_zero,
        output brl_neg,
        output out_tag
    );
endinterface

// File: rtl/brlshift_pipe.sv
// Pipelined barrel shifter: logical/arithmetic shift with signed count and rotate-right,
// with a valid/ready handshake, 1- or 2-stage pipeline, passthrough tag and result flags.
module brlshift_pipe #(
    parameter int WIDTH   = 32,
    parameter int LATENCY = 1,
    parameter int TAG_W   = 6
) (
    input  logic           sys_clk,
    input  logic           reset,
    brlshift_pipe_if.slave bus
);
    localparam int CW = $clog2(WIDTH);

    // Logarithmic shifter: each set bit of amt applies a shift of 2^k, so the
    // same routine serves both the full shift and either half of the pipeline.
    function automatic logic [WIDTH-1:0] shift_by(
        input logic [WIDTH-1:0] d,
        input logic [CW-1:0]    amt,
        input logic             left,
        input logic             rot,
        input logic             fill
    );
        logic [WIDTH-1:0] r;
        r = d;
        for (int k = 0; k < CW; k++) begin
            if (amt[k]) begin
                if (rot) begin
                    r = (r >> (1 << k)) | (r << (WIDTH - (1 << k)));
                end else if (left) begin
                    r = r << (1 << k);
                end else begin
                    r = (r >> (1 << k)) | (fill ? ~({WIDTH{1'b1}} >> (1 << k)) : '0);
                end
            end
        end
        return r;
    endfunction

    function automatic logic [WIDTH-1:0] finish_shift(
        input logic [WIDTH-1:0] d,
        input logic [CW-1:0]    amt,
        input logic             left,
        input logic             rot,
        input logic             oor,
        input logic             fill
    );
        logic [WIDTH-1:0] r;
        if (oor) begin
            r = {WIDTH{fill}};
        end else begin
            r = shift_by(d, amt, left, rot, fill);
        end
        return r;
    endfunction

    logic             dec_rot;
    logic             dec_sha;
    logic             cnt_neg;
    logic [WIDTH-1:0] cnt_mag;
    logic             dec_left;
    logic             dec_oor;
    logic             dec_right_nz;
    logic             dec_fill;
    logic             dec_carry;
    logic [CW-1:0]    dec_amt;

    // Decode the signed count into direction, magnitude and out-of-range.
    // The magnitude of the most negative count wraps to itself, which is
    // still >= WIDTH and so correctly lands in the out-of-range case.
    always_comb begin
        dec_rot      = (bus.brlmux == 2'b10);
        dec_sha      = (bus.brlmux == 2'b11);
        cnt_neg      = bus.srcdp[WIDTH-1];
        cnt_mag      = cnt_neg ? (~bus.srcdp + WIDTH'(1)) : bus.srcdp;
        dec_left     = ~dec_rot & cnt_neg;
        dec_oor      = ~dec_rot & (cnt_mag >= WIDTH'(WIDTH));
        dec_right_nz = ~dec_rot & ~cnt_neg & (bus.srcdp != '0);
        dec_fill     = dec_sha & ~cnt_neg & bus.brld[WIDTH-1];
        dec_carry    = (dec_oor | dec_right_nz) ? bus.brld[0] : bus.brld[WIDTH-1];
        dec_amt      = dec_rot ? bus.srcdp[CW-1:0] : cnt_mag[CW-1:0];
    end

    logic             in_rdy;
    logic             out_vld;
    logic [WIDTH-1:0] out_q;
    logic             out_carry;
    logic             out_zero;
    logic             out_neg;
    logic [TAG_W-1:0] out_tag_r;

    generate
        if (LATENCY == 1) begin : g_lat1
            logic [WIDTH-1:0] res;
            logic             load;

            always_comb begin
                res = finish_shift(bus.brld, dec_amt, dec_left, dec_rot, dec_oor, dec_fill);
            end

            assign in_rdy = ~out_vld | bus.out_ready;
            assign load   = bus.in_valid & in_rdy;

            // Single output register; holds its contents while the consumer stalls.
            always_ff @(posedge sys_clk) begin
                if (reset) begin
                    out_vld   <= 1'b0;
                    out_q     <= '0;
                    out_carry <= 1'b0;
                    out_zero  <= 1'b0;
                    out_neg   <= 1'b0;
                    out_tag_r <= '0;
                end else if (load) begin
                    out_vld   <= 1'b1;
                    out_q     <= res;
                    out_carry <= dec_carry;
                    out_zero  <= (res == '0);
                    out_neg   <= res[WIDTH-1];
                    out_tag_r <= bus.in_tag;
                end else if (bus.out_ready) begin
                    out_vld   <= 1'b0;
                end
            end
        end else begin : g_lat2
            localparam int            LO      = CW / 2;
            localparam logic [CW-1:0] LO_MASK = CW'((1 << LO) - 1);

            logic             s1_vld;
            logic             s1_left;
            logic             s1_rot;
            logic             s1_oor;
            logic             s1_fill;
            logic             s1_carry;
            logic [TAG_W-1:0] s1_tag;
            logic [WIDTH-1:0] s1_data;
            logic [CW-1:0]    s1_amt_lo;
            logic             s2_free;
            logic             s1_adv;
            logic             s1_load;
            logic [WIDTH-1:0] res;

            assign s2_free = ~out_vld | bus.out_ready;
            assign s1_adv  = s1_vld & s2_free;
            assign in_rdy  = ~s1_vld | s2_free;
            assign s1_load = bus.in_valid & in_rdy;

            // Stage 1 applies the upper half of the count; the lower half rides along.
            always_ff @(posedge sys_clk) begin
                if (reset) begin
                    s1_vld    <= 1'b0;
                    s1_left   <= 1'b0;
                    s1_rot    <= 1'b0;
                    s1_oor    <= 1'b0;
                    s1_fill   <= 1'b0;
                    s1_carry  <= 1'b0;
                    s1_tag    <= '0;
                    s1_data   <= '0;
                    s1_amt_lo <= '0;
                end else if (s1_load) begin
                    s1_vld    <= 1'b1;
                    s1_left   <= dec_left;
                    s1_rot    <= dec_rot;
                    s1_oor    <= dec_oor;
                    s1_fill   <= dec_fill;
                    s1_carry  <= dec_carry;
                    s1_tag    <= bus.in_tag;
                    s1_data   <= shift_by(bus.brld, dec_amt & ~LO_MASK, dec_left, dec_rot, dec_fill);
                    s1_amt_lo <= dec_amt & LO_MASK;
                end else if (s1_adv) begin
                    s1_vld    <= 1'b0;
                end
            end

            always_comb begin
                res = finish_shift(s1_data, s1_amt_lo, s1_left, s1_rot, s1_oor, s1_fill);
            end

            always_ff @(posedge sys_clk) begin
                if (reset) begin
                    out_vld   <= 1'b0;
                    out_q     <= '0;
                    out_carry <= 1'b0;
                    out_zero  <= 1'b0;
                    out_neg   <= 1'b0;
                    out_tag_r <= '0;
                end else if (s1_adv) begin
                    out_vld   <= 1'b1;
                    out_q     <= res;
                    out_carry <= s1_carry;
                    out_zero  <= (res == '0);
                    out_neg   <= res[WIDTH-1];
                    out_tag_r <= s1_tag;
                end else if (bus.out_ready) begin
                    out_vld   <= 1'b0;
                end
            end
        end
    endgenerate

    assign bus.in_ready  = in_rdy;
    assign bus.out_valid = out_vld;
    assign bus.brlq      = out_q;
    assign bus.brl_carry = out_carry;
    assign bus.brl_zero  = out_zero;
    assign bus.brl_neg   = out_neg;
    assign bus.out_tag   = out_tag_r;
endmodule

// File: tb/tb_brlshift_pipe.sv
// Bench for brlshift_pipe: a LATENCY=1 and a LATENCY=2 instance see the same stimulus,
// each tracked by its own scoreboard built from the shift rules with plain arithmetic.
module tb_brlshift_pipe;
    localparam int W  = 32;
    localparam int TW = 6;

    typedef struct {
        logic [W-1:0]  q;
        logic          carry;
        logic [TW-1:0] tag;
        int            ready;
    } exp_t;

    typedef struct {
        logic          in_ready;
        logic          out_valid;
        logic [W-1:0]  q;
        logic          carry;
        logic          zero;
        logic          neg;
        logic [TW-1:0] tag;
    } obs_t;

    logic          sys_clk;
    logic          reset;
    logic          in_valid;
    logic [1:0]    brlmux;
    logic [W-1:0]  srcdp;
    logic [W-1:0]  brld;
    logic [TW-1:0] in_tag;
    logic          out_ready;

    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    exp_t expq[2][$];
    obs_t prev_obs[2];
    bit   prev_stall[2];
    bit   just_reset[2];
    bit   last_fire[2];

    brlshift_pipe_if #(.WIDTH(W), .TAG_W(TW)) if1 ();
    brlshift_pipe_if #(.WIDTH(W), .TAG_W(TW)) if2 ();

    assign if1.in_valid  = in_valid;
    assign if1.brlmux    = brlmux;
    assign if1.srcdp     = srcdp;
    assign if1.brld      = brld;
    assign if1.in_tag    = in_tag;
    assign if1.out_ready = out_ready;
    assign if2.in_valid  = in_valid;
    assign if2.brlmux    = brlmux;
    assign if2.srcdp     = srcdp;
    assign if2.brld      = brld;
    assign if2.in_tag    = in_tag;
    assign if2.out_ready = out_ready;

    brlshift_pipe #(.WIDTH(W), .LATENCY(1), .TAG_W(TW)) u_dut1 (
        .sys_clk (sys_clk),
        .reset   (reset),
        .bus     (if1)
    );

    brlshift_pipe #(.WIDTH(W), .LATENCY(2), .TAG_W(TW)) u_dut2 (
        .sys_clk (sys_clk),
        .reset   (reset),
        .bus     (if2)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Reference: result and carry straight from the count's signed value.
    function automatic logic [W:0] model(input logic [1:0] mode, input logic [W-1:0] cnt,
                                         input logic [W-1:0] d);
        longint        c;
        logic [2*W-1:0] dd;
        logic [W-1:0]  q;
        logic          cy;
        c = longint'($signed(cnt));
        if (mode == 2'b10) begin
            dd = {d, d} >> cnt[4:0];
            q  = dd[W-1:0];
            cy = d[W-1];
        end else if (c > 0) begin
            cy = d[0];
            if (c >= W) q = (mode == 2'b11) ? {W{d[W-1]}} : '0;
            else if (mode == 2'b11) q = W'($signed(d) >>> c);
            else q = d >> c;
        end else if (c < 0) begin
            if (c <= -W) begin
                q  = '0;
                cy = d[0];
            end else begin
                q  = d << (-c);
                cy = d[W-1];
            end
        end else begin
            q  = d;
            cy = d[W-1];
        end
        return {cy, q};
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        total++;
        assert (got === want) else begin
            bad++;
            $error("[TB] FAIL %s got=%0h want=%0h", name, got, want);
        end
    endtask

    function automatic obs_t get_obs(input int lane);
        obs_t o;
        if (lane == 0) begin
            o.in_ready = if1.in_ready; o.out_valid = if1.out_valid; o.q = if1.brlq;
            o.carry = if1.brl_carry; o.zero = if1.brl_zero; o.neg = if1.brl_neg; o.tag = if1.out_tag;
        end else begin
            o.in_ready = if2.in_ready; o.out_valid = if2.out_valid; o.q = if2.brlq;
            o.carry = if2.brl_carry; o.zero = if2.brl_zero; o.neg = if2.brl_neg; o.tag = if2.out_tag;
        end
        return o;
    endfunction

    task automatic apply_stimulus(input logic v, input logic [1:0] mode, input logic [W-1:0] cnt,
                                  input logic [W-1:0] d, input logic [TW-1:0] tag, input logic ordy);
        in_valid  = v;
        brlmux    = mode;
        srcdp     = cnt;
        brld      = d;
        in_tag    = tag;
        out_ready = ordy;
    endtask

    task automatic check_output(input int lane);
        obs_t       o;
        exp_t       e;
        logic       exp_ov;
        logic       exp_ir;
        logic [W:0] m;
        string      ln;
        o      = get_obs(lane);
        ln     = (lane == 0) ? "L1" : "L2";
        exp_ov = 1'b0;
        if (expq[lane].size() > 0) exp_ov = (expq[lane][0].ready <= cyc);
        chk({ln, "/out_valid"}, 64'(o.out_valid), 64'(exp_ov));
        exp_ir = !((expq[lane].size() == lane + 1) && !out_ready);
        chk({ln, "/in_ready"}, 64'(o.in_ready), 64'(exp_ir));
        if (just_reset[lane]) begin
            chk({ln, "/rst_q"}, 64'(o.q), 64'(0));
            chk({ln, "/rst_flags"}, 64'({o.carry, o.zero, o.neg}), 64'(0));
            chk({ln, "/rst_tag"}, 64'(o.tag), 64'(0));
            just_reset[lane] = 1'b0;
        end
        if (prev_stall[lane]) begin
            chk({ln, "/stall_q"}, 64'(o.q), 64'(prev_obs[lane].q));
            chk({ln, "/stall_flags"}, 64'({o.carry, o.zero, o.neg}),
                64'({prev_obs[lane].carry, prev_obs[lane].zero, prev_obs[lane].neg}));
            chk({ln, "/stall_tag"}, 64'(o.tag), 64'(prev_obs[lane].tag));
        end
        if (o.out_valid && out_ready && expq[lane].size() > 0) begin
            e = expq[lane].pop_front();
            chk({ln, "/brlq"}, 64'(o.q), 64'(e.q));
            chk({ln, "/carry"}, 64'(o.carry), 64'(e.carry));
            chk({ln, "/zero"}, 64'(o.zero), 64'(e.q == '0));
            chk({ln, "/neg"}, 64'(o.neg), 64'(e.q[W-1]));
            chk({ln, "/out_tag"}, 64'(o.tag), 64'(e.tag));
        end
        last_fire[lane] = in_valid && o.in_ready;
        if (last_fire[lane]) begin
            m       = model(brlmux, srcdp, brld);
            e.q     = m[W-1:0];
            e.carry = m[W];
            e.tag   = in_tag;
            e.ready = cyc + lane + 1;
            expq[lane].push_back(e);
        end
        prev_stall[lane] = o.out_valid && !out_ready;
        prev_obs[lane]   = o;
    endtask

    task automatic cycle();
        #2;
        last_fire[0] = 1'b0;
        last_fire[1] = 1'b0;
        if (!reset) begin
            check_output(0);
            check_output(1);
        end
        @(posedge sys_clk);
        cyc++;
        if (reset) begin
            for (int l = 0; l < 2; l++) begin
                expq[l].delete();
                just_reset[l] = 1'b1;
                prev_stall[l] = 1'b0;
            end
        end
        #1;
    endtask

    task automatic directed(input string name, input logic [1:0] mode, input logic [W-1:0] cnt,
                            input logic [W-1:0] d, input logic [W-1:0] eq, input logic ec,
                            input logic [TW-1:0] tag);
        obs_t o;
        apply_stimulus(1'b1, mode, cnt, d, tag, 1'b1);
        cycle();
        apply_stimulus(1'b0, mode, cnt, d, tag, 1'b1);
        o = get_obs(0);
        chk({name, "/L1q"}, 64'(o.q), 64'(eq));
        chk({name, "/L1c"}, 64'(o.carry), 64'(ec));
        chk({name, "/L1zn"}, 64'({o.zero, o.neg}), 64'({eq == '0, eq[W-1]}));
        cycle();
        o = get_obs(1);
        chk({name, "/L2q"}, 64'(o.q), 64'(eq));
        chk({name, "/L2c"}, 64'(o.carry), 64'(ec));
        cycle();
    endtask

    function automatic logic [W-1:0] rand_count();
        int edges[6];
        edges = '{32, -32, 31, -31, 33, 0};
        case ($urandom % 4)
            0: return W'($urandom);
            1: return W'(int'($urandom_range(0, 80)) - 40);
            2: return W'(edges[$urandom % 6]);
            default: return W'($urandom_range(0, 33));
        endcase
    endfunction

    initial begin
        int   k;
        obs_t o;
        logic [3:0] pat;
        reset = 1'b1;
        apply_stimulus(1'b0, 2'b00, '0, '0, '0, 1'b1);
        cycle();
        cycle();
        reset = 1'b0;

        directed("sh_r4",   2'b00, 32'd4,         32'h8000_00F1, 32'h0800_000F, 1'b1, 6'd1);
        directed("sh_l4",   2'b01, 32'hFFFF_FFFC, 32'h8000_00F1, 32'h0000_0F10, 1'b1, 6'd2);
        directed("sha_r8",  2'b11, 32'd8,         32'h8000_0000, 32'hFF80_0000, 1'b0, 6'd3);
        directed("sha_r40", 2'b11, 32'd40,        32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 6'd4);
        directed("sh_m32",  2'b00, 32'hFFFF_FFE0, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 6'd5);
        directed("sh_m31",  2'b00, 32'hFFFF_FFE1, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, 6'd6);
        directed("ror4",    2'b10, 32'h0000_0024, 32'h1234_5678, 32'h8123_4567, 1'b0, 6'd7);
        directed("ror0",    2'b10, 32'h0000_0000, 32'h1234_5678, 32'h1234_5678, 1'b0, 6'd8);
        directed("sha_m32", 2'b11, 32'hFFFF_FFE0, 32'h8000_0001, 32'h0000_0000, 1'b1, 6'd9);
        directed("sh_r32",  2'b00, 32'd32,        32'h8000_0001, 32'h0000_0000, 1'b1, 6'd10);
        directed("sh_0",    2'b00, 32'd0,         32'h8000_0001, 32'h8000_0001, 1'b1, 6'd11);

        $display("[TB] back-pressure burst");
        pat = 4'b1001;
        k   = 0;
        for (int i = 0; i < 100 && k < 6; i++) begin
            apply_stimulus(1'b1, 2'($urandom), rand_count(), W'($urandom), TW'(k), pat[i % 4]);
            cycle();
            if (last_fire[1]) k++;
        end
        chk("burst_issued", 64'(k), 64'(6));
        for (int i = 0; i < 12; i++) begin
            apply_stimulus(1'b0, 2'b00, '0, '0, '0, pat[i % 4]);
            cycle();
        end

        $display("[TB] random traffic");
        for (int i = 0; i < 400; i++) begin
            apply_stimulus(($urandom % 4) != 0, 2'($urandom), rand_count(), W'($urandom),
                           TW'($urandom), ($urandom % 3) != 0);
            cycle();
        end
        for (int i = 0; i < 6; i++) begin
            apply_stimulus(1'b0, 2'b00, '0, '0, '0, 1'b1);
            cycle();
        end
        chk("drained_L1", 64'(expq[0].size()), 64'(0));
        chk("drained_L2", 64'(expq[1].size()), 64'(0));

        $display("[TB] reset with ops in flight");
        for (int i = 0; i < 3; i++) begin
            apply_stimulus(1'b1, 2'b11, W'(i + 1), 32'hF0F0_1234, TW'(20 + i), 1'b0);
            cycle();
        end
        chk("inflight_L2", 64'(expq[1].size()), 64'(2));
        reset = 1'b1;
        apply_stimulus(1'b1, 2'b00, 32'd1, 32'hFFFF_FFFF, 6'h3F, 1'b0);
        cycle();
        reset = 1'b0;
        apply_stimulus(1'b1, 2'b00, 32'hFFFF_FFFF, 32'h0000_0001, 6'h2A, 1'b1);
        cycle();
        apply_stimulus(1'b0, 2'b00, '0, '0, '0, 1'b1);
        cycle();
        o = get_obs(1);
        chk("post_rst_valid", 64'(o.out_valid), 64'(1));
        chk("post_rst_tag", 64'(o.tag), 64'(6'h2A));
        chk("post_rst_q", 64'(o.q), 64'(32'h0000_0002));
        cycle();
        cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/brlshift_pipe.md
Name: brlshift_pipe

Overview:
- Parametrised, pipelined successor to the GPU/DSP ALU barrel-shift path.
- Executes SH (logical, signed count), SHA (arithmetic, signed count) and ROR on WIDTH-bit operands.
- Adds a valid/ready handshake, 1- or 2-stage pipelining, a passthrough tag, and zero/negative flags alongside carry.
- Sits between the register-file operand latch and the ALU result mux of the next-generation RISC core.

Parameters:
- WIDTH, 32, operand/result width; power of two, 8..64. CW = log2(WIDTH) is derived, not a parameter.
- LATENCY, 1, number of pipeline register stages; legal values 1 or 2.
- TAG_W, 6, width of the opaque tag carried with each operation.

Ports:
- sys_clk  in  1  system clock; all state on the rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  operation present on the inputs.
- in_ready  out  1  block accepts the operation this cycle.
- brlmux  in  2  mode: 00/01 = SH, 10 = ROR, 11 = SHA.
- srcdp  in  WIDTH  shift count, two's complement.
- brld  in  WIDTH  data to shift.
- in_tag  in  TAG_W  tag returned with the result.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- brlq  out  WIDTH  shifted result.
- brl_carry  out  1  carry flag.
- brl_zero  out  1  brlq == 0.
- brl_neg  out  1  brlq[WIDTH-1].
- out_tag  out  TAG_W  tag of the result.

Behaviour:
- Count c = signed(srcdp).
  - SH/SHA, c > 0: shift right by c. SH fills with 0; SHA fills with brld[WIDTH-1].
  - SH/SHA, c < 0: shift left by -c, filling with 0.
  - SH/SHA, c == 0: brlq = brld.
- Out of range (SH/SHA only): c >= WIDTH or c <= -WIDTH.
  - Right, SH: brlq = 0.
  - Right, SHA: brlq = all copies of brld[WIDTH-1].
  - Left, either mode: brlq = 0.
  - c = -WIDTH is out of range. c = -(WIDTH-1) is in range.
- ROR: rotate right by srcdp[CW-1:0]; all upper bits of srcdp are ignored. A count of 0 passes brld through.
- brl_carry:
  - brld[0] when SH/SHA has c > 0, including out-of-range right.
  - brld[0] for out-of-range left.
  - brld[WIDTH-1] for in-range c < 0, for c == 0, and for ROR.
- brl_zero and brl_neg are computed from the final brlq.
- Pipeline, LATENCY=1:
  - Decode and the full shift are combinational into a single output register.
  - An accepted input appears on the outputs the next cycle.
- Pipeline, LATENCY=2:
  - Stage 1 registers: mode, direction, out-of-range flag, fill bit, carry, tag, and data already shifted by count bits [CW-1:CW/2].
  - Stage 2 applies count bits [CW/2-1:0] and computes the flags. An accepted input appears on the outputs two cycles later.
- Handshake:
  - Transfer in: in_valid & in_ready. Transfer out: out_valid & out_ready.
  - Each stage loads when it is empty or its contents leave the same cycle (bubble collapse).
  - in_ready = ~stage1_valid | stage1_advances. No combinational path exists from in_valid to out_valid.
  - Throughput is 1 op/cycle while out_ready=1.
- Stall: with out_valid=1 and out_ready=0, brlq, flags and out_tag hold stable. No operation is dropped or duplicated.
- Simultaneous transfer in and out on a full pipe: both occur and occupancy is unchanged.
- Reset:
  - All stage valids clear, so out_valid=0.
  - brlq, brl_carry, brl_zero, brl_neg and out_tag clear to 0.
  - in_ready=1 in the first cycle after reset is deasserted.
  - Reset mid-operation discards in-flight ops. An input presented during reset is not accepted.
- Input values while in_valid=0 have no effect on state.

Test Plan:
- WIDTH=32, LATENCY=1, SH:
  - srcdp=4, brld=0x8000_00F1 -> brlq=0x0800_000F, carry=1.
  - srcdp=-4 (0xFFFF_FFFC) -> brlq=0x0000_0F10, carry=1.
- SHA: srcdp=8, brld=0x8000_0000 -> brlq=0xFF80_0000, neg=1, carry=0. srcdp=40 -> brlq=0xFFFF_FFFF.
- Range edges: SH srcdp=-32, brld=0xFFFF_FFFF -> brlq=0, zero=1, carry=1. SH srcdp=-31 -> brlq=0x8000_0000.
- ROR: srcdp=0x0000_0024 (count 4), brld=0x1234_5678 -> brlq=0x8123_4567, carry=0. srcdp=0 -> brlq=0x1234_5678.
- LATENCY=2 back-pressure:
  - Issue 6 ops with tags 0..5 while out_ready toggles 1,0,0,1.
  - Required: results in order with matching out_tag, outputs stable during stalls, in_ready=0 only when both stages are full and stalled.
- Reset with 2 ops in flight -> out_valid=0 and all outputs 0 the next cycle. The first op issued after reset returns with the correct tag after 2 cycles.
